motor_ramp: RTL and testbench
=============================

Name: motor_ramp

Overview:
- Upstream stage of the motor PWM driver.
- Accepts signed two's-complement speed targets for the left and right motors.
- Saturates them and slew-rate limits the drive command toward each target.
- Forces a zero-magnitude dead interval before any direction reversal.
- Outputs are 11-bit sign-magnitude commands: bit10 = reverse, [9:0] = duty. They feed the driver's lft/rht inputs directly.

Parameters:
- RAMP_DIV, 512: clocks per ramp tick (≥1).
- STEP, 8: maximum magnitude change per tick (1..1023).
- DEAD_TICKS, 4: ticks held at zero magnitude before a sign change (0 = no dwell).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tgt_lft  in  12  signed left target
- tgt_rht  in  12  signed right target
- tgt_vld  in  1  capture both targets this cycle
- en  in  1  drive enable; low forces effective targets to 0
- lft  out  11  left command {reverse, mag[9:0]}
- rht  out  11  right command {reverse, mag[9:0]}
- at_tgt  out  1  both channels settled on target
- reversing  out  1  either channel in DEAD state

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at posedge):
  - lft=rht=11'h000, sign=0, state RUN.
  - Prescaler=0, dead counters=0, target regs=0.
  - at_tgt=1, reversing=0.
  - Rst mid-ramp or mid-DEAD aborts immediately.
- Target capture: tgt_vld high → both target regs load on that edge. The new values take effect from the next tick.
- Prescaler: counts 0..RAMP_DIV-1. tick=1 for one cycle when count==RAMP_DIV-1, then wraps to 0. RAMP_DIV=1 gives a tick every cycle.
- Effective target (combinational, per channel):
  - e = en ? tgt_reg : 0.
  - t_sign = e[11].
  - t_mag = min(|e|, 1023); -2048 saturates to 1023.
  - t_mag==0 → t_sign treated as current sign (never triggers a reversal).
- Per-channel FSM, advances only on tick; outputs are registered and update at the tick edge.
  - RUN, t_sign==sign: mag moves toward t_mag by min(STEP, |t_mag-mag|); never overshoots.
  - RUN, t_sign!=sign, mag>0: mag -= min(STEP, mag).
  - RUN, t_sign!=sign, mag==0:
    - DEAD_TICKS==0 → sign<=t_sign, stay RUN.
    - Otherwise → DEAD, dcnt<=DEAD_TICKS-1.
  - DEAD: mag held 0.
    - t_sign==sign (target reverted or zero) → RUN, no flip.
    - Else dcnt==0 → sign<=t_sign, RUN.
    - Else dcnt--.
  - Total dwell is DEAD_TICKS ticks at zero before the flip tick; the first nonzero mag appears on the following tick.
- at_tgt (combinational from regs): both channels in RUN, mag==t_mag, and (t_mag==0 or sign==t_sign).
- Magnitude never exceeds 1023. The sign bit never changes while mag≠0.
- Simultaneous tgt_vld and tick: the tick uses the old target; the new one applies on the next tick.

Optional Feature:
- Macro: MOTOR_RAMP_BRAKE_EN.
- Defined: when a channel's effective t_mag==0, that channel's mag clears to 0 on the next clock edge, regardless of tick. State returns to RUN and sign is unchanged. Downstream, zero magnitude drives both fwd and rev high, i.e. brake.
- Undefined: a zero target ramps down at STEP per tick like any other target.

Decomposition:
- Package motor_ramp_pkg:
  - MAG_W=10, MAG_MAX=10'd1023.
  - typedef enum logic {RUN, DEAD} ramp_state_t.
  - typedef struct packed {logic rev; logic [9:0] mag;} motor_cmd_t.
- Sub-module motor_ramp_chan: one channel's saturation, FSM and dead counter. Inputs: clk, rst, tick, target, en. Outputs: cmd, settled, in_dead.
- Top instantiates it twice and holds the shared prescaler and target registers.

Test Plan (RAMP_DIV=4, STEP=16, DEAD_TICKS=2 unless noted):
1. Reset: assert rst 2 cycles → lft=rht=11'h000, at_tgt=1, reversing=0. Rst held 1 cycle mid-ramp → all outputs zero next edge.
2. Ramp: tgt_lft=+100, tgt_vld pulse → lft mag 16,32,48,64,80,96,100 on successive ticks (every 4 clocks); bit10=0; at_tgt rises with 100.
3. Saturation: tgt_rht=+1500 → settles at 11'h3FF. tgt_rht=-2048 → ramps down, reverses, settles at 11'h7FF.
4. Reversal: lft at +40, tgt_lft=-20 → mag 24, 8, 0; then 2 dead ticks with reversing=1; sign flips; then 16, 20 with bit10=1. With DEAD_TICKS=0: 24, 8, 0 (flip), 16, 20.
5. Abort reversal: in DEAD, tgt_lft back to +30 → next tick RUN, sign stays 0, mag 16, then 30.
6. Enable/brake: at +200, en=0 → ramps 184,168,…,0 without the macro. With MOTOR_RAMP_BRAKE_EN → mag=0 on the next clock.

Source files
------------

// File: rtl/motor_ramp_pkg.sv
// Shared types and helpers for the motor_ramp slew-rate limiter.
package motor_ramp_pkg;

    localparam int MAG_W = 10;
    localparam logic [MAG_W-1:0] MAG_MAX = 10'd1023;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } ramp_state_t;

    typedef struct packed {
        logic             rev;
        logic [MAG_W-1:0] mag;
    } motor_cmd_t;

    // Magnitude of a 12-bit two's-complement value, clamped to MAG_MAX.
    // -2048 negates to 12'h800, which the clamp catches as out of range.
    function automatic logic [MAG_W-1:0] sat_mag(input logic [11:0] e);
        logic [11:0] a;
        a = e[11] ? (~e + 12'd1) : e;
        if (a > {2'b00, MAG_MAX}) begin
            return MAG_MAX;
        end
        return a[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/motor_ramp_chan.sv
// One motor channel: target saturation, slew limiting and reversal dwell.
// Optional macro MOTOR_RAMP_BRAKE_EN: a zero effective target clears the
// magnitude on the next clock instead of ramping down.
module motor_ramp_chan
    import motor_ramp_pkg::*;
#(
    parameter int STEP       = 8,
    parameter int DEAD_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [11:0] target,
    input  logic        en,
    output motor_cmd_t  cmd,
    output logic        settled,
    output logic        in_dead
);

    localparam int DCNT_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [MAG_W-1:0]  STEP_M    = MAG_W'(STEP);
    localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'((DEAD_TICKS > 0) ? DEAD_TICKS - 1 : 0);

    ramp_state_t       state_q, state_d;
    logic              sign_q, sign_d;
    logic [MAG_W-1:0]  mag_q, mag_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;

    logic [11:0]       eff;
    logic [MAG_W-1:0]  t_mag;
    logic              t_sign;
    logic [MAG_W-1:0]  diff;

    // Effective target, next-state and per-tick magnitude update.
    always_comb begin
        eff     = en ? target : '0;
        t_mag   = sat_mag(eff);
        // A zero target carries no direction, so it never requests a reversal.
        t_sign  = (t_mag == '0) ? sign_q : eff[11];
        diff    = '0;
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        dcnt_d  = dcnt_q;

        if (tick) begin
            if (state_q == RUN) begin
                if (t_sign == sign_q) begin
                    if (mag_q < t_mag) begin
                        diff  = t_mag - mag_q;
                        mag_d = mag_q + ((diff > STEP_M) ? STEP_M : diff);
                    end else begin
                        diff  = mag_q - t_mag;
                        mag_d = mag_q - ((diff > STEP_M) ? STEP_M : diff);
                    end
                end else if (mag_q != '0) begin
                    mag_d = mag_q - ((mag_q > STEP_M) ? STEP_M : mag_q);
                end else if (DEAD_TICKS == 0) begin
                    sign_d = t_sign;
                end else begin
                    state_d = DEAD;
                    dcnt_d  = DCNT_LOAD;
                end
            end else begin
                mag_d = '0;
                if (t_sign == sign_q) begin
                    state_d = RUN;
                end else if (dcnt_q == '0) begin
                    sign_d  = t_sign;
                    state_d = RUN;
                end else begin
                    dcnt_d = dcnt_q - DCNT_W'(1);
                end
            end
        end

`ifdef MOTOR_RAMP_BRAKE_EN
        // Brake overrides the tick-paced update; direction is kept.
        if (t_mag == '0) begin
            mag_d   = '0;
            state_d = RUN;
            sign_d  = sign_q;
            dcnt_d  = '0;
        end
`endif
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Status and command outputs derived from the registers.
    always_comb begin
        cmd.rev = sign_q;
        cmd.mag = mag_q;
        settled = (state_q == RUN) && (mag_q == t_mag) &&
                  ((t_mag == '0) || (sign_q == t_sign));
        in_dead = (state_q == DEAD);
    end

endmodule

// File: rtl/motor_ramp.sv
// motor_ramp: dual-channel slew-rate limiter feeding the motor PWM driver.
// Holds the shared ramp prescaler and target registers.
// Optional macro MOTOR_RAMP_BRAKE_EN (see motor_ramp_chan).
module motor_ramp
    import motor_ramp_pkg::*;
#(
    parameter int RAMP_DIV   = 512,
    parameter int STEP       = 8,
    parameter int DEAD_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] tgt_lft,
    input  logic [11:0] tgt_rht,
    input  logic        tgt_vld,
    input  logic        en,
    output logic [10:0] lft,
    output logic [10:0] rht,
    output logic        at_tgt,
    output logic        reversing
);

    localparam int PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(RAMP_DIV - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic [11:0]     tgt_lft_q, tgt_lft_d;
    logic [11:0]     tgt_rht_q, tgt_rht_d;
    logic            tick;

    motor_cmd_t      lft_cmd, rht_cmd;
    logic            lft_settled, rht_settled;
    logic            lft_dead, rht_dead;

    // Prescaler wrap and target capture.
    always_comb begin
        tick      = (ps_q == PS_LAST);
        ps_d      = tick ? '0 : ps_q + PS_W'(1);
        tgt_lft_d = tgt_vld ? tgt_lft : tgt_lft_q;
        tgt_rht_d = tgt_vld ? tgt_rht : tgt_rht_q;
    end

    // Shared registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q      <= '0;
            tgt_lft_q <= '0;
            tgt_rht_q <= '0;
        end else begin
            ps_q      <= ps_d;
            tgt_lft_q <= tgt_lft_d;
            tgt_rht_q <= tgt_rht_d;
        end
    end

    motor_ramp_chan #(
        .STEP       (STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_lft (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .target  (tgt_lft_q),
        .en      (en),
        .cmd     (lft_cmd),
        .settled (lft_settled),
        .in_dead (lft_dead)
    );

    motor_ramp_chan #(
        .STEP       (STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_rht (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .target  (tgt_rht_q),
        .en      (en),
        .cmd     (rht_cmd),
        .settled (rht_settled),
        .in_dead (rht_dead)
    );

    // Combine channel status into the block outputs.
    always_comb begin
        lft       = lft_cmd;
        rht       = rht_cmd;
        at_tgt    = lft_settled && rht_settled;
        reversing = lft_dead || rht_dead;
    end

endmodule

// File: tb/tb_motor_ramp.sv
// Scoreboard bench for motor_ramp with a signed-arithmetic reference model.
module tb_motor_ramp;

    localparam int RAMP_DIV   = 4;
    localparam int STEP       = 16;
    localparam int DEAD_TICKS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] tgt_lft = '0;
    logic [11:0] tgt_rht = '0;
    logic        tgt_vld = 1'b0;
    logic        en = 1'b1;
    logic [10:0] lft, rht;
    logic        at_tgt, reversing;

    int checks = 0;
    int failures = 0;

    motor_ramp #(
        .RAMP_DIV   (RAMP_DIV),
        .STEP       (STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_lft   (tgt_lft),
        .tgt_rht   (tgt_rht),
        .tgt_vld   (tgt_vld),
        .en        (en),
        .lft       (lft),
        .rht       (rht),
        .at_tgt    (at_tgt),
        .reversing (reversing)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] lft;
        logic [10:0] rht;
        logic        at;
        logic        rev;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: velocity as sign flag + magnitude, dwell flags.
    int mmag[2];
    int ms[2];
    int mdwl[2];
    int mrem[2];
    int mtgt[2];
    int mps;
    bit mvalid = 0;

    function automatic int sat(input int x);
        if (x > 1023) return 1023;
        if (x < -1023) return -1023;
        return x;
    endfunction

    function automatic int eff_tgt(input int ch);
        return en ? sat(mtgt[ch]) : 0;
    endfunction

    // Model update on each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int c = 0; c < 2; c++) begin
                    mmag[c] = 0; ms[c] = 0; mdwl[c] = 0; mrem[c] = 0; mtgt[c] = 0;
                end
                mps = 0;
                mvalid = 1;
            end else if (mvalid) begin
                bit tk;
                tk = (mps == RAMP_DIV - 1);
                mps = tk ? 0 : mps + 1;
                for (int c = 0; c < 2; c++) begin
                    int t, v, d;
                    bit same;
                    t = eff_tgt(c);
                    same = (t == 0) || ((t < 0) == (ms[c] == 1));
                    if (tk) begin
                        if (mdwl[c] != 0) begin
                            if (same) mdwl[c] = 0;
                            else if (mrem[c] == 0) begin ms[c] = 1 - ms[c]; mdwl[c] = 0; end
                            else mrem[c] = mrem[c] - 1;
                        end else if (same) begin
                            v = (ms[c] != 0) ? -mmag[c] : mmag[c];
                            d = t - v;
                            if (d > STEP) d = STEP;
                            if (d < -STEP) d = -STEP;
                            v = v + d;
                            mmag[c] = (v < 0) ? -v : v;
                        end else if (mmag[c] > 0) begin
                            mmag[c] = mmag[c] - ((mmag[c] > STEP) ? STEP : mmag[c]);
                        end else if (DEAD_TICKS == 0) begin
                            ms[c] = 1 - ms[c];
                        end else begin
                            mdwl[c] = 1;
                            mrem[c] = DEAD_TICKS - 1;
                        end
                    end
`ifdef MOTOR_RAMP_BRAKE_EN
                    if (t == 0) begin
                        mmag[c] = 0;
                        mdwl[c] = 0;
                    end
`endif
                end
                if (tgt_vld) begin
                    mtgt[0] = int'($signed(tgt_lft));
                    mtgt[1] = int'($signed(tgt_rht));
                end
            end
        end
    end

    // Expected outputs for the current cycle go into the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mvalid && !rst) begin
                exp_t e;
                int vl, vr;
                vl = (ms[0] != 0) ? -mmag[0] : mmag[0];
                vr = (ms[1] != 0) ? -mmag[1] : mmag[1];
                e.lft = {ms[0][0], 10'(mmag[0])};
                e.rht = {ms[1][0], 10'(mmag[1])};
                e.at  = (mdwl[0] == 0) && (mdwl[1] == 0) &&
                        (vl == eff_tgt(0)) && (vr == eff_tgt(1));
                e.rev = (mdwl[0] != 0) || (mdwl[1] != 0);
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: pop and compare against the DUT outputs.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (lft !== e.lft) begin
                    failures++;
                    $display("FAIL lft t=%0t got=%h exp=%h", $time, lft, e.lft);
                end
                checks++;
                if (rht !== e.rht) begin
                    failures++;
                    $display("FAIL rht t=%0t got=%h exp=%h", $time, rht, e.rht);
                end
                checks++;
                if (at_tgt !== e.at) begin
                    failures++;
                    $display("FAIL at_tgt t=%0t got=%b exp=%b", $time, at_tgt, e.at);
                end
                checks++;
                if (reversing !== e.rev) begin
                    failures++;
                    $display("FAIL reversing t=%0t got=%b exp=%b", $time, reversing, e.rev);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int l, input int r);
        tgt_lft = 12'(l);
        tgt_rht = 12'(r);
        tgt_vld = 1'b1;
        step(1);
        tgt_vld = 1'b0;
    endtask

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);

        load(100, 0);
        step(40);

        load(100, 1500);
        step(300);
        load(100, -2048);
        step(600);

        load(40, -2048);
        step(40);
        load(-20, -2048);
        step(50);

        load(40, 0);
        step(40);
        load(-20, 0);
        step(18);
        load(30, 0);
        step(30);

        load(200, 0);
        step(60);
        en = 1'b0;
        step(80);
        en = 1'b1;
        step(60);

        load(500, -500);
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(20);

        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel < 10) begin
                load(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
            end else if (sel < 16) begin
                load(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100);
            end else if (sel < 19) begin
                en = ~en;
            end else begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
            step(int'($urandom_range(1, 24)));
        end
        en = 1'b1;
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
